// File: rtl/cpu_param.sv
// Parametrised accumulator CPU (A, B, output register, carry flag) with stall, HALT/resume and output strobe.
// Latency: each accepted instruction updates pc/registers/flags on the next clk_cpu rising edge; no pipelining.
// Backpressure: inst_valid=0 freezes all state; HALT holds everything until resume is seen.
module cpu_param #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic [DATA_W+3:0] inst,
    input  logic              inst_valid,
    input  logic [DATA_W-1:0] io_in,
    input  logic              resume,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_stb,
    output logic              carry,
    output logic              halted
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [3:0]             op;
    logic [DATA_W-1:0]      im;
    logic [DATA_W-1:0]      src;
    logic [DATA_W:0]        sum;
    logic [DATA_W-1:0]      a, b, a_nxt, b_nxt, io_out_nxt;
    logic [PC_W-1:0]        pc_nxt, pc_inc, jmp_tgt;
    logic [DATA_W+PC_W-1:0] im_ext;
    logic                   carry_nxt, stb_nxt;

    assign op      = inst[DATA_W+3:DATA_W];
    assign im      = inst[DATA_W-1:0];
    // Widening first then taking the low PC_W bits gives zero-extension or truncation as needed.
    assign im_ext  = {{PC_W{1'b0}}, im};
    assign jmp_tgt = im_ext[PC_W-1:0];
    assign pc_inc  = pc + 1'b1;
    assign sum     = {1'b0, src} + {1'b0, im};
    assign halted  = (state == HALT);

    // ALU source selection by opcode; MOV-immediate, OUT Im, jumps and NOPs add to zero.
    always_comb begin
        src = '0;
        case (op)
            4'b0000, 4'b0100:          src = a;
            4'b0101, 4'b0001, 4'b1001: src = b;
            4'b0010, 4'b0110:          src = io_in;
            default:                   src = '0;
        endcase
    end

    // Next-state and register-update decode; everything holds unless an instruction executes.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        a_nxt      = a;
        b_nxt      = b;
        io_out_nxt = io_out;
        carry_nxt  = carry;
        stb_nxt    = 1'b0;
        if (state == HALT) begin
            if (resume) begin
                state_nxt = RUN;
                pc_nxt    = pc_inc;
            end
        end else if (inst_valid) begin
            pc_nxt    = pc_inc;
            carry_nxt = sum[DATA_W];
            case (op)
                4'b0000, 4'b0011, 4'b0001, 4'b0010: a_nxt = sum[DATA_W-1:0];
                4'b0101, 4'b0111, 4'b0100, 4'b0110: b_nxt = sum[DATA_W-1:0];
                4'b1001, 4'b1011: begin
                    io_out_nxt = sum[DATA_W-1:0];
                    stb_nxt    = 1'b1;
                end
                4'b1111: pc_nxt = jmp_tgt;
                4'b1110: begin
                    carry_nxt = carry;
                    if (!carry) pc_nxt = jmp_tgt;
                end
                4'b1000: begin
                    carry_nxt = carry;
                    pc_nxt    = pc;
                    state_nxt = HALT;
                end
                default: ;
            endcase
        end
    end

    // State, program counter, data registers and flags.
    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            pc         <= '0;
            a          <= '0;
            b          <= '0;
            io_out     <= '0;
            carry      <= 1'b0;
            io_out_stb <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            io_out     <= io_out_nxt;
            carry      <= carry_nxt;
            io_out_stb <= stb_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_param.sv
// Self-checking bench for cpu_param: directed program walk, randomized run against a reference model,
// asynchronous reset mid-halt, and an 8-bit data / 6-bit pc instance for jump-target truncation.
module tb_cpu_param;

    logic       clk_cpu = 1'b0;
    logic       reset;
    logic [7:0] inst;
    logic       inst_valid;
    logic [3:0] io_in;
    logic       resume;
    logic [3:0] pc;
    logic [3:0] io_out;
    logic       io_out_stb;
    logic       carry;
    logic       halted;

    logic [11:0] inst8;
    logic        valid8;
    logic [7:0]  io_in8;
    logic        resume8;
    logic [5:0]  pc8;
    logic [7:0]  io_out8;
    logic        stb8;
    logic        carry8;
    logic        halted8;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state (plain integers)
    int ma, mb, mo, mc, mpc, mstb, mhalt;

    always #5 clk_cpu = ~clk_cpu;

    cpu_param #(.DATA_W(4), .PC_W(4)) dut (
        .clk_cpu(clk_cpu), .reset(reset), .inst(inst), .inst_valid(inst_valid),
        .io_in(io_in), .resume(resume), .pc(pc), .io_out(io_out),
        .io_out_stb(io_out_stb), .carry(carry), .halted(halted)
    );

    cpu_param #(.DATA_W(8), .PC_W(6)) dut8 (
        .clk_cpu(clk_cpu), .reset(reset), .inst(inst8), .inst_valid(valid8),
        .io_in(io_in8), .resume(resume8), .pc(pc8), .io_out(io_out8),
        .io_out_stb(stb8), .carry(carry8), .halted(halted8)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mo = 0; mc = 0; mpc = 0; mstb = 0; mhalt = 0;
    endtask

    // Architectural behaviour: value = (source + Im) mod 16, carry = (source + Im) >= 16.
    task automatic model_step(input logic [7:0] i, input logic v, input logic [3:0] d, input logic r);
        int op, im, s, nxt;
        mstb = 0;
        if (mhalt != 0) begin
            if (r) begin
                mhalt = 0;
                mpc   = (mpc + 1) % 16;
            end
        end else if (v) begin
            op  = int'(i[7:4]);
            im  = int'(i[3:0]);
            nxt = (mpc + 1) % 16;
            case (op)
                0:  begin s = ma + im;        ma = s % 16; mc = s / 16; end
                5:  begin s = mb + im;        mb = s % 16; mc = s / 16; end
                3:  begin s = im;             ma = s;      mc = 0;      end
                7:  begin s = im;             mb = s;      mc = 0;      end
                1:  begin s = mb + im;        ma = s % 16; mc = s / 16; end
                4:  begin s = ma + im;        mb = s % 16; mc = s / 16; end
                2:  begin s = int'(d) + im;   ma = s % 16; mc = s / 16; end
                6:  begin s = int'(d) + im;   mb = s % 16; mc = s / 16; end
                9:  begin s = mb + im;        mo = s % 16; mc = s / 16; mstb = 1; end
                11: begin mo = im; mc = 0; mstb = 1; end
                15: begin nxt = im; mc = 0; end
                14: begin if (mc == 0) nxt = im; end
                8:  begin mhalt = 1; nxt = mpc; end
                default: mc = 0;
            endcase
            mpc = nxt;
        end
    endtask

    task automatic step(input string tag, input logic [7:0] i, input logic v,
                        input logic [3:0] d, input logic r);
        inst = i; inst_valid = v; io_in = d; resume = r;
        model_step(i, v, d, r);
        @(posedge clk_cpu);
        #1;
        check({tag, ".pc"},     int'(pc),         mpc);
        check({tag, ".io_out"}, int'(io_out),     mo);
        check({tag, ".stb"},    int'(io_out_stb), mstb);
        check({tag, ".carry"},  int'(carry),      mc);
        check({tag, ".halted"}, int'(halted),     mhalt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".pc"},     int'(pc),         0);
        check({tag, ".io_out"}, int'(io_out),     0);
        check({tag, ".stb"},    int'(io_out_stb), 0);
        check({tag, ".carry"},  int'(carry),      0);
        check({tag, ".halted"}, int'(halted),     0);
        check({tag, ".pc8"},    int'(pc8),        0);
    endtask

    initial begin
        logic [3:0] rop, rim;
        reset = 1'b1; inst = '0; inst_valid = 1'b0; io_in = '0; resume = 1'b0;
        inst8 = '0; valid8 = 1'b0; io_in8 = '0; resume8 = 1'b0;
        model_reset();
        #12;
        check_all_zero("reset");
        reset = 1'b0;

        // Carry generation and JNC not-taken / taken
        step("mov_a3",  8'h33, 1'b1, 4'h0, 1'b0);
        step("add_a14", 8'h0E, 1'b1, 4'h0, 1'b0);
        check("add_a14.carry_plan", int'(carry), 1);
        step("jnc5",    8'hE5, 1'b1, 4'h0, 1'b0);
        check("jnc5.pc_plan", int'(pc), 3);
        step("mov_ba",  8'h40, 1'b1, 4'h0, 1'b0);
        check("mov_ba.carry_plan", int'(carry), 0);
        step("jnc9",    8'hE9, 1'b1, 4'h0, 1'b0);
        check("jnc9.pc_plan", int'(pc), 9);

        // Output strobes, including back-to-back OUTs
        step("out_im9", 8'hB9, 1'b1, 4'h0, 1'b0);
        check("out_im9.io_plan", int'(io_out), 9);
        check("out_im9.stb_plan", int'(io_out_stb), 1);
        step("mov_b6",  8'h76, 1'b1, 4'h0, 1'b0);
        check("mov_b6.stb_plan", int'(io_out_stb), 0);
        step("out_b",   8'h90, 1'b1, 4'h0, 1'b0);
        check("out_b.io_plan", int'(io_out), 6);
        step("out_b2",  8'h90, 1'b1, 4'h0, 1'b0);
        check("out_b2.stb_plan", int'(io_out_stb), 1);

        // Stall: three cycles without inst_valid, then one accepted ADD A,1 (A: 1 -> 2)
        for (int k = 0; k < 3; k++) step("stall", 8'h01, 1'b0, 4'h0, 1'b0);
        step("add_a1",  8'h01, 1'b1, 4'h0, 1'b0);
        step("mov_ba2", 8'h40, 1'b1, 4'h0, 1'b0);
        step("out_a2",  8'h90, 1'b1, 4'h0, 1'b0);
        check("out_a2.io_plan", int'(io_out), 2);

        // HALT at pc=4, held for 5 cycles, then resume
        step("jmp4", 8'hF4, 1'b1, 4'h0, 1'b0);
        step("hlt",  8'h80, 1'b1, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++)
            step("halt_hold", 8'(($urandom_range(0, 255))), 1'($urandom_range(0, 1)), 4'h5, 1'b0);
        check("halt_hold.pc_plan", int'(pc), 4);
        step("resume", 8'h00, 1'b1, 4'h0, 1'b1);
        check("resume.pc_plan", int'(pc), 5);
        check("resume.halted_plan", int'(halted), 0);

        // pc wrap, then reset asserted mid-halt
        step("jmp15", 8'hFF, 1'b1, 4'h0, 1'b0);
        step("nop",   8'hA0, 1'b1, 4'h0, 1'b0);
        check("nop.pc_wrap", int'(pc), 0);
        step("jmp6",   8'hF6, 1'b1, 4'h0, 1'b0);
        step("out_im5", 8'hB5, 1'b1, 4'h0, 1'b0);
        step("hlt2",   8'h80, 1'b1, 4'h0, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset");
        model_reset();
        @(negedge clk_cpu);
        reset = 1'b0;

        // Randomized program run against the model
        for (int k = 0; k < 400; k++) begin
            rop = 4'($urandom_range(0, 15));
            rim = 4'($urandom_range(0, 15));
            if (rop == 4'h8 && $urandom_range(0, 3) != 0) rop = 4'hA;
            if (rop == 4'h1 || rop == 4'h4 || rop == 4'h2 || rop == 4'h6 || rop == 4'h9) rim = 4'h0;
            step("rand", {rop, rim}, 1'($urandom_range(0, 4) != 0),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
        end

        // 8-bit data, 6-bit pc instance
        inst_valid = 1'b0; resume = 1'b0;
        reset = 1'b1;
        #1 check("w8.reset_pc", int'(pc8), 0);
        @(negedge clk_cpu);
        reset = 1'b0;
        valid8 = 1'b1;
        inst8 = 12'h302; @(posedge clk_cpu); #1;
        check("w8.mov_pc", int'(pc8), 1);
        inst8 = 12'h0FF; @(posedge clk_cpu); #1;
        check("w8.add_carry", int'(carry8), 1);
        check("w8.add_pc", int'(pc8), 2);
        inst8 = 12'h400; @(posedge clk_cpu); #1;
        check("w8.movba_carry", int'(carry8), 0);
        inst8 = 12'h900; @(posedge clk_cpu); #1;
        check("w8.out_a", int'(io_out8), 1);
        check("w8.out_stb", int'(stb8), 1);
        inst8 = 12'hF47; @(posedge clk_cpu); #1;
        check("w8.jmp_trunc", int'(pc8), 7);
        check("w8.stb_clear", int'(stb8), 0);
        check("w8.halted", int'(halted8), 0);
        valid8 = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
